dmem_arbiter: RTL and testbench

//   Shares the single-port word-addressed data memory between two requesters:
//   m0 = core load/store path, m1 = debug/loader port.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin req/ack arbiter sharing a single-port word memory
//            between the core load/store path (m0) and a debug/loader (m1).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_we,
    output logic [31:0]   mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q,    state_d;
    logic                  sel_q,      sel_d;
    logic                  we_q,       we_d;
    logic [DEPTH_LOG2-1:0] idx_q,      idx_d;
    logic [DW-1:0]         wd_q,       wd_d;
    logic                  prio_q,     prio_d;
    logic                  m0_ack_q,   m0_ack_d;
    logic                  m1_ack_q,   m1_ack_d;
    logic [DW-1:0]         m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]         m1_rdata_q, m1_rdata_d;

    logic                  w_grant_m1;
    logic [DEPTH_LOG2-1:0] w_m0_idx;
    logic [DEPTH_LOG2-1:0] w_m1_idx;
    logic                  w_unused_addr_bits;

    // Byte offset and bits above the memory size are dropped: accesses round
    // down to a word and alias modulo the memory size.
    assign w_m0_idx = m0_addr[DEPTH_LOG2+1:2];
    assign w_m1_idx = m1_addr[DEPTH_LOG2+1:2];
    assign w_unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0],
                                  m0_addr[AW-1:DEPTH_LOG2+2],
                                  m1_addr[AW-1:DEPTH_LOG2+2]};

    assign w_grant_m1 = m1_req & (~m0_req | prio_q);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        prio_d     = prio_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    sel_d   = w_grant_m1;
                    we_d    = w_grant_m1 ? m1_we    : m0_we;
                    idx_d   = w_grant_m1 ? w_m1_idx : w_m0_idx;
                    wd_d    = w_grant_m1 ? m1_wdata : m0_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Captured on writes too, returning the pre-write contents.
                if (sel_q) begin
                    m1_rdata_d = mem_rd;
                    m1_ack_d   = 1'b1;
                end else begin
                    m0_rdata_d = mem_rd;
                    m0_ack_d   = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                prio_d  = ~sel_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wd_q       <= '0;
            prio_q     <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            prio_q     <= prio_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

    // Reset gates the strobe directly so an in-flight write is never committed.
    assign mem_we = (state_q == S_ACCESS) & we_q & ~rst;
    assign mem_a  = {{(32-DEPTH_LOG2){1'b0}}, idx_q};
    assign mem_wd = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter with a behavioural word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:1023];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          order_q[$];
    time         time_q[$];
    logic [31:0] last0 = 32'h0;
    logic [31:0] last1 = 32'h0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DW(32), .AW(32), .DEPTH_LOG2(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    end
    always @(posedge clk) if (mem_we === 1'b1) mem[mem_a[9:0]] <= mem_wd;
    assign mem_rd = mem[mem_a[9:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected read word whenever an ack appears.
    always @(negedge clk) begin
        logic [31:0] e;
        if (m0_ack === 1'b1 && m1_ack === 1'b1) check("dual_ack", 32'd1, 32'd0);
        if (m0_ack === 1'b1) begin
            if (q0.size() == 0) check("m0_unexpected_ack", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("m0_rdata", m0_rdata, e);
                check("m1_rdata_hold", m1_rdata, last1);
                last0 = e;
            end
            order_q.push_back(0);
            time_q.push_back($time);
        end
        if (m1_ack === 1'b1) begin
            if (q1.size() == 0) check("m1_unexpected_ack", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("m1_rdata", m1_rdata, e);
                check("m0_rdata_hold", m0_rdata, last0);
                last1 = e;
            end
            order_q.push_back(1);
            time_q.push_back($time);
        end
    end

    // Called just after a rising edge; returns just after the edge closing ack.
    task automatic access(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
        int n;
        if (m == 0) begin
            q0.push_back(exp);
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            q1.push_back(exp);
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((m == 0 ? m0_ack : m1_ack) === 1'b1) break;
            if (n > 20) begin
                check(m == 0 ? "m0_ack_timeout" : "m1_ack_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;

        // 1. Reset with both requests pending, then m0 wins first
        repeat (2) begin
            @(negedge clk);
            check("rst_m0_ack", m0_ack, 0);
            check("rst_m1_ack", m1_ack, 0);
            check("rst_m0_rdata", m0_rdata, 0);
            check("rst_m1_rdata", m1_rdata, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_a", mem_a, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        fork
            access(0, 1'b0, 32'h0, 32'h0, 32'h0);
            access(1, 1'b0, 32'h4, 32'h0, 32'h0);
        join

        // 3. Continuous contention: strict alternation, 3 cycles apart
        fork
            repeat (2) access(0, 1'b0, 32'h8, 32'h0, 32'h0);
            repeat (2) access(1, 1'b0, 32'hC, 32'h0, 32'h0);
        join
        check("order_count", order_q.size(), 6);
        for (int i = 0; i < 6 && i < order_q.size(); i++)
            check("grant_order", order_q[i], i % 2);
        for (int i = 1; i < 6 && i < time_q.size(); i++)
            check("ack_spacing", 32'(time_q[i] - time_q[i-1]), 32'd30);

        // 2. m0 write with latency checks, then read back
        fork
            access(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
            begin
                @(negedge clk);
                check("t2_idle_mem_we", mem_we, 0);
                check("t2_idle_ack", m0_ack, 0);
                @(negedge clk);
                check("t2_access_mem_we", mem_we, 1);
                check("t2_access_mem_a", mem_a, 32'h4);
                check("t2_access_mem_wd", mem_wd, 32'hDEADBEEF);
                @(negedge clk);
                check("t2_done_m0_ack", m0_ack, 1);
                check("t2_done_mem_we", mem_we, 0);
                check("t2_done_mem_a_hold", mem_a, 32'h4);
            end
        join
        access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        access(0, 1'b0, 32'h12, 32'h0, 32'hDEADBEEF);

        // 4. Aliasing and misalignment
        access(1, 1'b1, 32'h1003, 32'h55, 32'h0);
        access(0, 1'b0, 32'h0, 32'h0, 32'h55);
        access(0, 1'b0, 32'h1000, 32'h0, 32'h55);

        // 6. Read-before-write
        access(0, 1'b1, 32'h20, 32'h5, 32'h0);
        access(0, 1'b1, 32'h20, 32'hA, 32'h5);
        access(0, 1'b0, 32'h20, 32'h0, 32'hA);

        // 5. Reset during an m1 write
        access(0, 1'b1, 32'h8, 32'h1111, 32'h0);
        access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        m1_we = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h1234; m1_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_access_mem_we", mem_we, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_gates_we", mem_we, 0);
        @(posedge clk); #1;
        rst = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
        last0 = 32'h0; last1 = 32'h0;
        check("t5_m0_rdata_cleared", m0_rdata, 0);
        check("t5_mem_a_cleared", mem_a, 0);
        repeat (4) begin
            @(negedge clk);
            check("t5_no_m1_ack", m1_ack, 0);
        end
        @(posedge clk); #1;
        access(0, 1'b0, 32'h8, 32'h0, 32'h1111);

        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
